tt_um_cnt_monitor: RTL and testbench

//  Receive-side checker for the 8-bit free-running counter tile. The counter runs in a foreign

---
 rtl/cnt_mon_pkg.sv | 26 ++
 rtl/cnt_mon_sync_filter.sv | 85 ++++++++
 rtl/tt_um_cnt_monitor.sv | 178 +++++++++++++++++
 tb/tb_tt_um_cnt_monitor.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_mon_pkg.sv
// Shared types and constants for the counter-tile receive monitor.
//   state_e      : monitor FSM state, 2-bit encoding visible on the status readout
//   SEL_*        : uo_out readout select codes (uio_in[1:0])
//   UIO_OE_MASK  : fixed bidirectional output-enable pattern
//   sat_inc8     : 8-bit increment that sticks at 255
package cnt_mon_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAcq   = 2'd1,
        StTrack = 2'd2,
        StErr   = 2'd3
    } state_e;

    localparam logic [1:0] SEL_ACC_VAL = 2'd0;
    localparam logic [1:0] SEL_RATE    = 2'd1;
    localparam logic [1:0] SEL_ERR_CNT = 2'd2;
    localparam logic [1:0] SEL_STATUS  = 2'd3;

    localparam logic [7:0] UIO_OE_MASK = 8'hF0;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/cnt_mon_sync_filter.sv
// Synchroniser plus stability filter for the 8-bit counter pins.
//   clk_i      : system clock
//   rst_ni     : synchronous active-low reset
//   data_i     : raw counter pins, asynchronous to clk_i
//   acc_o      : one-cycle accept strobe, valid together with acc_data_o
//   acc_data_o : value being accepted while acc_o is high
//   acc_val_o  : last accepted value (registered)
module cnt_mon_sync_filter
    import cnt_mon_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned STABLE_CYC  = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] data_i,
    output logic       acc_o,
    output logic [7:0] acc_data_o,
    output logic [7:0] acc_val_o
);

    localparam int unsigned StabW = $clog2(STABLE_CYC + 1);
    localparam logic [StabW-1:0] StabMax  = StabW'(STABLE_CYC);
    localparam logic [StabW-1:0] StabFire = StabW'(STABLE_CYC - 1);

    logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;
    // Tracks which sync stages hold a real sample since reset, so the
    // reset-zero contents of the chain are never mistaken for a pin value.
    logic [SYNC_STAGES-1:0]      vld_q, vld_d;
    logic [7:0]                  cand_q, cand_d;
    logic                        cand_vld_q, cand_vld_d;
    logic [StabW-1:0]            stab_q, stab_d;
    logic [7:0]                  acc_val_q, acc_val_d;

    logic [7:0] s;
    logic       s_vld;
    logic       acc;

    assign s     = sync_q[SYNC_STAGES-1];
    assign s_vld = vld_q[SYNC_STAGES-1];

    // stab saturates one above the fire point so the strobe cannot repeat.
    assign acc = cand_vld_q && (stab_q == StabFire) && (s == cand_q);

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], data_i};
        vld_d      = {vld_q[SYNC_STAGES-2:0], 1'b1};
        cand_d     = cand_q;
        cand_vld_d = cand_vld_q;
        stab_d     = stab_q;
        acc_val_d  = acc ? cand_q : acc_val_q;
        if (s_vld) begin
            if (!cand_vld_q || (s != cand_q)) begin
                cand_d     = s;
                cand_vld_d = 1'b1;
                stab_d     = '0;
            end else if (stab_q != StabMax) begin
                stab_d = stab_q + StabW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q     <= '0;
            vld_q      <= '0;
            cand_q     <= '0;
            cand_vld_q <= 1'b0;
            stab_q     <= '0;
            acc_val_q  <= '0;
        end else begin
            sync_q     <= sync_d;
            vld_q      <= vld_d;
            cand_q     <= cand_d;
            cand_vld_q <= cand_vld_d;
            stab_q     <= stab_d;
            acc_val_q  <= acc_val_d;
        end
    end

    assign acc_o      = acc;
    assign acc_data_o = cand_q;
    assign acc_val_o  = acc_val_q;

endmodule

// File: rtl/tt_um_cnt_monitor.sv
// Receive-side checker for the free-running 8-bit counter tile.
// Accepts stable pin values, checks each change is +1 mod 256, measures the
// step rate over a 2**WIN_LOG2 cycle window and reports on the tile pins.
//   clk     : system clock
//   rst_n   : synchronous active-low reset
//   ena     : tile enable; low forces IDLE and freezes counters
//   ui_in   : counter value from transmitter tile (asynchronous)
//   uio_in  : [1:0] readout select, [2] clear errors (level)
//   uo_out  : selected readout, registered
//   uio_out : [7] locked, [6] err_pulse, [5] win_tick, [4] wrap_pulse
//   uio_oe  : constant output-enable mask
module tt_um_cnt_monitor
    import cnt_mon_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned STABLE_CYC  = 2,
    parameter int unsigned WIN_LOG2    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic       acc;
    logic [7:0] acc_data;
    logic [7:0] acc_val;

    cnt_mon_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .STABLE_CYC  (STABLE_CYC)
    ) u_sync_filter (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .data_i     (ui_in),
        .acc_o      (acc),
        .acc_data_o (acc_data),
        .acc_val_o  (acc_val)
    );

    state_e              state_q, state_d;
    logic [7:0]          ref_val_q, ref_val_d;
    logic [7:0]          step_cnt_q, step_cnt_d;
    logic [7:0]          rate_q, rate_d;
    logic [7:0]          err_cnt_q, err_cnt_d;
    logic                err_sticky_q, err_sticky_d;
    logic                wrap_seen_q, wrap_seen_d;
    logic [WIN_LOG2-1:0] win_cnt_q, win_cnt_d;
    logic                err_pulse_q, err_pulse_d;
    logic                wrap_pulse_q, wrap_pulse_d;
    logic                win_tick_q, win_tick_d;
    logic [7:0]          uo_out_q, uo_out_d;

    logic       clr;
    logic [1:0] sel;
    logic       step_inc;
    logic       err_inc;
    logic       wrap;
    logic [7:0] next_val;
    logic       unused_uio;

    assign clr        = uio_in[2];
    assign sel        = uio_in[1:0];
    assign unused_uio = ^uio_in[7:3];
    assign next_val   = ref_val_q + 8'd1;

    always_comb begin
        state_d      = state_q;
        ref_val_d    = ref_val_q;
        step_inc     = 1'b0;
        err_inc      = 1'b0;
        wrap         = 1'b0;

        if (!ena) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: state_d = StAcq;
                StAcq: begin
                    if (acc) begin
                        ref_val_d = acc_data;
                        state_d   = StTrack;
                    end
                end
                StTrack, StErr: begin
                    if (acc) begin
                        if (acc_data == next_val) begin
                            ref_val_d = acc_data;
                            step_inc  = 1'b1;
                            wrap      = (ref_val_q == 8'hFF);
                            state_d   = StTrack;
                        end else if ((state_q == StTrack) && (acc_data == ref_val_q)) begin
                            // Same value re-accepted after a rejected glitch.
                        end else begin
                            ref_val_d = acc_data;
                            err_inc   = 1'b1;
                            state_d   = StErr;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        err_pulse_d  = err_inc;
        wrap_pulse_d = wrap;

        // Window timer; a step landing on the last cycle is folded into rate.
        win_cnt_d  = win_cnt_q;
        step_cnt_d = step_inc ? sat_inc8(step_cnt_q) : step_cnt_q;
        rate_d     = rate_q;
        win_tick_d = 1'b0;
        if (ena) begin
            win_cnt_d = win_cnt_q + WIN_LOG2'(1);
            if (&win_cnt_q) begin
                rate_d     = step_cnt_d;
                step_cnt_d = '0;
                win_tick_d = 1'b1;
            end
        end

        err_cnt_d    = err_inc ? sat_inc8(err_cnt_q) : err_cnt_q;
        err_sticky_d = err_sticky_q | err_inc;
        wrap_seen_d  = wrap_seen_q | wrap;
        if (clr) begin
            err_cnt_d    = '0;
            err_sticky_d = 1'b0;
            wrap_seen_d  = 1'b0;
        end

        unique case (sel)
            SEL_ACC_VAL: uo_out_d = acc_val;
            SEL_RATE:    uo_out_d = rate_q;
            SEL_ERR_CNT: uo_out_d = err_cnt_q;
            SEL_STATUS:  uo_out_d = {state_q, err_sticky_q, wrap_seen_q, 4'b0000};
            default:     uo_out_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            ref_val_q    <= '0;
            step_cnt_q   <= '0;
            rate_q       <= '0;
            err_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
            wrap_seen_q  <= 1'b0;
            win_cnt_q    <= '0;
            err_pulse_q  <= 1'b0;
            wrap_pulse_q <= 1'b0;
            win_tick_q   <= 1'b0;
            uo_out_q     <= '0;
        end else begin
            state_q      <= state_d;
            ref_val_q    <= ref_val_d;
            step_cnt_q   <= step_cnt_d;
            rate_q       <= rate_d;
            err_cnt_q    <= err_cnt_d;
            err_sticky_q <= err_sticky_d;
            wrap_seen_q  <= wrap_seen_d;
            win_cnt_q    <= win_cnt_d;
            err_pulse_q  <= err_pulse_d;
            wrap_pulse_q <= wrap_pulse_d;
            win_tick_q   <= win_tick_d;
            uo_out_q     <= uo_out_d;
        end
    end

    assign uo_out  = uo_out_q;
    assign uio_out = {(state_q == StTrack), err_pulse_q, win_tick_q, wrap_pulse_q, 4'b0000};
    assign uio_oe  = UIO_OE_MASK;

endmodule

// File: tb/tb_tt_um_cnt_monitor.sv
module tb_tt_um_cnt_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks = 0;
    int n_fail   = 0;
    int n_err    = 0;
    int n_wrap   = 0;
    int n_tick   = 0;

    always #5 clk = ~clk;

    tt_um_cnt_monitor #(
        .SYNC_STAGES (2),
        .STABLE_CYC  (2),
        .WIN_LOG2    (6)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    // Pulse counters; the bench only reads these after its own #1 delay.
    always @(negedge clk) begin
        if (rst_n) begin
            if (uio_out[6]) n_err++;
            if (uio_out[4]) n_wrap++;
            if (uio_out[5]) n_tick++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic set_val(input logic [7:0] v);
        ui_in = v;
        tick(8);
    endtask

    task automatic read_sel(input logic [1:0] s, output logic [7:0] v);
        uio_in[1:0] = s;
        tick(2);
        v = uo_out;
    endtask

    task automatic wait_locked(input string tag);
        int k = 0;
        while (!uio_out[7] && k < 60) begin
            tick(1);
            k++;
        end
        check(tag, 32'(uio_out[7]), 32'd1);
    endtask

    task automatic do_reset(input logic [7:0] v);
        rst_n = 1'b0;
        ui_in = v;
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] rd;
        int e0, w0, t0, cyc, n_rate;
        bit pend;

        // 1: reset with ena high, then IDLE -> ACQ -> lock on the held value
        ena    = 1'b1;
        uio_in = 8'h03;
        do_reset(8'h00);
        rst_n = 1'b0;
        check("rst_uo_out", 32'(uo_out), 32'h00);
        check("rst_uio_out", 32'(uio_out), 32'h00);
        check("uio_oe", 32'(uio_oe), 32'hF0);
        rst_n = 1'b1;
        tick(1);
        check("idle_readout", 32'(uo_out), 32'h00);
        tick(1);
        check("acq_readout", 32'(uo_out), 32'h40);
        wait_locked("lock_after_rst");
        read_sel(2'd3, rd);
        check("track_readout", 32'(rd), 32'h80);

        // 2: clean count, one step per 8 clk, rate 8 per 64-cycle window
        e0 = n_err;
        uio_in[1:0] = 2'd1;
        cyc    = 0;
        n_rate = 0;
        pend   = 1'b0;
        for (int v = 1; v <= 40; v++) begin
            ui_in = 8'(v);
            for (int c = 0; c < 8; c++) begin
                tick(1);
                cyc++;
                if (pend) begin
                    check("rate_8", 32'(uo_out), 32'd8);
                    n_rate++;
                end
                pend = uio_out[5] && (cyc >= 100) && (cyc <= 315);
            end
        end
        check("rate_windows_seen", 32'(n_rate >= 2), 32'd1);
        check("clean_no_err", 32'(n_err - e0), 32'd0);
        check("clean_locked", 32'(uio_out[7]), 32'd1);
        read_sel(2'd2, rd);
        check("clean_err_cnt", 32'(rd), 32'd0);
        read_sel(2'd0, rd);
        check("clean_acc_val", 32'(rd), 32'h28);

        // 3: reset mid-operation, then wrap through 0xFF -> 0x00
        do_reset(8'hFE);
        wait_locked("lock_at_fe");
        read_sel(2'd2, rd);
        check("rst_err_cnt", 32'(rd), 32'd0);
        e0 = n_err;
        w0 = n_wrap;
        set_val(8'hFF);
        set_val(8'h00);
        set_val(8'h01);
        check("wrap_once", 32'(n_wrap - w0), 32'd1);
        check("wrap_no_err", 32'(n_err - e0), 32'd0);
        read_sel(2'd3, rd);
        check("wrap_status", 32'(rd), 32'h90);

        // 4: jump 0x20 -> 0x25 is an error, 0x26 recovers
        do_reset(8'h20);
        wait_locked("lock_at_20");
        e0 = n_err;
        set_val(8'h25);
        check("jump_err_pulse", 32'(n_err - e0), 32'd1);
        check("jump_unlocked", 32'(uio_out[7]), 32'd0);
        read_sel(2'd2, rd);
        check("jump_err_cnt", 32'(rd), 32'd1);
        read_sel(2'd3, rd);
        check("jump_status_err", 32'(rd), 32'hE0);
        set_val(8'h26);
        check("recover_locked", 32'(uio_out[7]), 32'd1);
        read_sel(2'd3, rd);
        check("recover_status", 32'(rd), 32'hA0);

        // 5: single-cycle glitch to 0x27 is filtered out
        e0 = n_err;
        ui_in = 8'h27;
        tick(1);
        ui_in = 8'h26;
        tick(8);
        check("glitch_no_err", 32'(n_err - e0), 32'd0);
        check("glitch_locked", 32'(uio_out[7]), 32'd1);
        read_sel(2'd0, rd);
        check("glitch_acc_val", 32'(rd), 32'h26);
        read_sel(2'd2, rd);
        check("glitch_err_cnt", 32'(rd), 32'd1);
        set_val(8'h27);
        check("post_glitch_step", 32'(n_err - e0), 32'd0);

        // 6: clear errors, then ena low freezes rate, ena high relocks
        set_val(8'h40);
        set_val(8'h50);
        read_sel(2'd2, rd);
        check("err_cnt_3", 32'(rd), 32'd3);
        uio_in[2] = 1'b1;
        tick(1);
        uio_in[2] = 1'b0;
        tick(2);
        check("clear_err_cnt", 32'(uo_out), 32'd0);
        read_sel(2'd3, rd);
        check("clear_status", 32'(rd), 32'hC0);
        set_val(8'h51);
        check("relock_51", 32'(uio_out[7]), 32'd1);
        uio_in[1:0] = 2'd1;
        for (int v = 8'h52; v <= 8'h65; v++) set_val(8'(v));
        check("rate_before_ena", 32'(uo_out), 32'd8);
        t0  = n_tick;
        ena = 1'b0;
        for (int v = 8'h66; v <= 8'h6F; v++) set_val(8'(v));
        check("ena0_no_tick", 32'(n_tick - t0), 32'd0);
        check("ena0_rate_held", 32'(uo_out), 32'd8);
        check("ena0_unlocked", 32'(uio_out[7]), 32'd0);
        read_sel(2'd3, rd);
        check("ena0_idle", 32'(rd), 32'h00);
        e0  = n_err;
        ena = 1'b1;
        read_sel(2'd3, rd);
        check("ena1_acq", 32'(rd), 32'h40);
        set_val(8'h70);
        set_val(8'h71);
        check("ena1_locked", 32'(uio_out[7]), 32'd1);
        check("ena1_no_err", 32'(n_err - e0), 32'd0);
        read_sel(2'd0, rd);
        check("ena1_acc_val", 32'(rd), 32'h71);
        read_sel(2'd2, rd);
        check("ena1_err_cnt", 32'(rd), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
